// File: rtl/ccm_arb_pkg.sv
// Shared types and constants for the CCM arbiter.
package ccm_arb_pkg;

    localparam int unsigned CCM_WORDS = 8192;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned LANES     = 4;
    localparam int unsigned DATA_W    = LANES * LANE_W;
    localparam int unsigned HOLD_W    = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Write-side payload of the winning master.
    typedef struct packed {
        logic [LANES-1:0]  we;
        logic [DATA_W-1:0] wdata;
    } ccm_wr_t;

    // Wrap a requester index into 0..n-1.
    function automatic int unsigned rr_wrap(input int unsigned i, input int unsigned n);
        return i % n;
    endfunction

    // Index following i in rotation order.
    function automatic int unsigned rr_next(input int unsigned i, input int unsigned n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/ccm_arbiter_rr_pick.sv
// One-hot requester picker: round-robin from ptr, or fixed priority
// (lowest index wins) when CCM_ARB_FIXED_PRIO_EN is defined.
module ccm_arbiter_rr_pick
    import ccm_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
`ifndef CCM_ARB_FIXED_PRIO_EN
    input  logic [IW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] gnt_c,
    output logic [IW-1:0]   idx_c,
    output logic            valid_c
);

`ifdef CCM_ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last to win.
    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_c    = '0;
                gnt_c[k] = 1'b1;
                idx_c    = IW'(k);
                valid_c  = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] cand;

    // First requester found walking forward from ptr wins.
    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'(rr_wrap(32'(ptr) + 32'(k), NREQ));
            if (!valid_c && req[cand]) begin
                gnt_c[cand] = 1'b1;
                idx_c       = cand;
                valid_c     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ccm_arbiter.sv
// CCM arbiter: shares the single-port CCM between NREQ masters with
// round-robin grant, optional bounded lock, 1-cycle read return.
// Build option: CCM_ARB_FIXED_PRIO_EN selects fixed priority instead of RR.
module ccm_arbiter
    import ccm_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned AW       = $clog2(CCM_WORDS),
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*4-1:0]    we,
    input  logic [NREQ*32-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [31:0]          rdata,
    output logic [AW-1:0]        mem_addr,
    output logic [3:0]           mem_we,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [AW-1:0]     last_addr_q;
    logic [NREQ-1:0]   rvalid_q;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;
    logic              release_c;
    logic [NREQ-1:0]   gnt_c;
    logic [IW-1:0]     win_idx;
    logic              any_gnt;
    logic [AW-1:0]     win_addr;
    ccm_wr_t           win_wr;

`ifndef CCM_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     pick_ptr;

    // A released lock restarts the search just after the former owner.
    always_comb begin
        pick_ptr = release_c ? IW'(rr_next(32'(owner_q), NREQ)) : rr_q;
    end
`endif

    ccm_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
`ifndef CCM_ARB_FIXED_PRIO_EN
        .ptr     (pick_ptr),
`endif
        .gnt_c   (pick_gnt),
        .idx_c   (pick_idx),
        .valid_c (pick_vld)
    );

    // Grant selection: lock owner exclusively, otherwise the picker.
    always_comb begin
        release_c = (state_q == LOCKED) &&
                    (!req[owner_q] || (hold_q == HOLD_W'(LOCK_MAX)));
        gnt_c   = '0;
        win_idx = pick_idx;
        if (!rstn) begin
            gnt_c = '0;
        end else if ((state_q == LOCKED) && !release_c) begin
            gnt_c[owner_q] = 1'b1;
            win_idx        = owner_q;
        end else if (pick_vld) begin
            gnt_c = pick_gnt;
        end
        any_gnt = |gnt_c;
    end

    // Route the winner onto the memory port; address holds when idle.
    always_comb begin
        win_addr     = addr[32'(win_idx) * AW +: AW];
        win_wr.we    = we[32'(win_idx) * LANES +: LANES];
        win_wr.wdata = wdata[32'(win_idx) * DATA_W +: DATA_W];
        mem_addr     = any_gnt ? win_addr : last_addr_q;
        mem_we       = any_gnt ? win_wr.we : '0;
        mem_wdata    = win_wr.wdata;
    end

    assign gnt    = gnt_c;
    assign rvalid = rvalid_q;
    assign rdata  = mem_rdata;

    // Lock FSM next state, hold counter and rotation pointer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
`ifndef CCM_ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        if ((state_q == IDLE) || release_c) begin
            if (release_c) begin
                state_d = IDLE;
                hold_d  = '0;
`ifndef CCM_ARB_FIXED_PRIO_EN
                rr_d    = IW'(rr_next(32'(owner_q), NREQ));
`endif
            end
            if (any_gnt) begin
                if (lock[win_idx]) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                    hold_d  = HOLD_W'(1);
                end else begin
                    state_d = IDLE;
`ifndef CCM_ARB_FIXED_PRIO_EN
                    rr_d    = IW'(rr_next(32'(win_idx), NREQ));
`endif
                end
            end
        end else begin
            if (lock[owner_q]) begin
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                state_d = IDLE;
                hold_d  = '0;
`ifndef CCM_ARB_FIXED_PRIO_EN
                rr_d    = IW'(rr_next(32'(owner_q), NREQ));
`endif
            end
        end
    end

    // State registers and the read-return pipeline stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            hold_q      <= '0;
            last_addr_q <= '0;
            rvalid_q    <= '0;
`ifndef CCM_ARB_FIXED_PRIO_EN
            rr_q        <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            rvalid_q <= (any_gnt && (win_wr.we == '0)) ? gnt_c : '0;
            if (any_gnt) begin
                last_addr_q <= win_addr;
            end
`ifndef CCM_ARB_FIXED_PRIO_EN
            rr_q <= rr_d;
`endif
        end
    end

endmodule
